// File: rtl/ph_table_ctrl.sv
// Per-router ACO pheromone table: initialises every entry, arbitrates the
// input ports round-robin and serialises lookup / reinforce operations.
module ph_table_ctrl #(
    parameter int N        = 5,
    parameter int NODES    = 16,
    parameter int PH_WIDTH = 4,
    parameter int PH_MAX   = 15,
    parameter int PH_MIN   = 0,
    parameter int PH_INIT  = 8,
    parameter int PH_INC   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [0:N-1]                           i_req,
    input  logic [0:N-1]                           i_op,
    input  logic [0:N-1][$clog2(NODES)-1:0]        i_dest,
    input  logic [0:N-1][0:N-2]                    i_avail,
    input  logic [0:N-1][$clog2(N)-1:0]            i_parent,
    output logic [0:N-1]                           o_gnt,
    output logic [0:N-1]                           o_rsp_valid,
    output logic [$clog2(N)-1:0]                   o_rsp_port,
    output logic [PH_WIDTH-1:0]                    o_rsp_value,
    output logic                                   o_init_done,
    output logic [0:NODES-1][0:N-2][PH_WIDTH-1:0]  o_test_pheromones
);

    localparam int DW = $clog2(NODES);
    localparam int PW = $clog2(N);
    localparam int EW = PH_WIDTH + 1;

    typedef logic [PH_WIDTH-1:0] ph_t;
    typedef logic [0:N-2][PH_WIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_EXEC
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] cnt_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_q;
    logic          op_q;
    logic [DW-1:0] dest_q;
    logic [0:N-2]  avail_q;
    logic [PW-1:0] parent_q;
    logic          dest_ok_q;
    row_t          row_q;
    logic [PW-1:0] rsp_port_q;
    ph_t           rsp_value_q;

    logic [0:NODES-1][0:N-2][PH_WIDTH-1:0] table_q;

    logic          dest_ok;
    logic          gnt_any;
    logic [PW-1:0] gnt_sel;
    logic          best_found;
    logic [PW-1:0] best_port;
    ph_t           best_val;
    logic          par_ok;
    ph_t           par_val;
    row_t          new_row;
    logic [PW-1:0] exec_port;
    ph_t           exec_value;

    assign dest_ok = int'(dest_q) < NODES;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_sel = '0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!gnt_any && i_req[idx]) begin
                gnt_any = 1'b1;
                gnt_sel = PW'(idx);
            end
        end
    end

    // Strict '>' keeps the lowest column on ties.
    always_comb begin
        best_found = 1'b0;
        best_port  = '0;
        best_val   = '0;
        for (int c = 0; c < N - 1; c++) begin
            if (avail_q[c] && (!best_found || row_q[c] > best_val)) begin
                best_found = 1'b1;
                best_port  = PW'(c + 1);
                best_val   = row_q[c];
            end
        end
    end

    // Reinforce / evaporate in one extra bit so neither end can wrap.
    always_comb begin
        logic [EW-1:0] ext;
        ext     = '0;
        par_ok  = (parent_q != '0) && (int'(parent_q) <= N - 1);
        par_val = '0;
        new_row = row_q;
        for (int c = 0; c < N - 1; c++) begin
            ext = {1'b0, row_q[c]};
            if (par_ok && int'(parent_q) == c + 1) begin
                ext = ext + EW'(PH_INC);
                if (ext > EW'(PH_MAX)) begin
                    ext = EW'(PH_MAX);
                end
                par_val = ext[PH_WIDTH-1:0];
            end else if (ext > EW'(PH_MIN)) begin
                ext = ext - EW'(1);
            end else begin
                ext = EW'(PH_MIN);
            end
            new_row[c] = ext[PH_WIDTH-1:0];
        end
    end

    always_comb begin
        exec_port  = '0;
        exec_value = '0;
        if (op_q) begin
            exec_port  = parent_q;
            exec_value = dest_ok_q ? par_val : '0;
        end else if (dest_ok_q && best_found) begin
            exec_port  = best_port;
            exec_value = best_val;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_gnt       = '0;
        o_rsp_valid = '0;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == DW'(NODES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (gnt_any) begin
                    o_gnt[gnt_sel] = 1'b1;
                    state_d        = S_READ;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                o_rsp_valid[gnt_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Result is live during the pulse and held from registers afterwards.
    assign o_rsp_port        = (state_q == S_EXEC) ? exec_port : rsp_port_q;
    assign o_rsp_value       = (state_q == S_EXEC) ? exec_value : rsp_value_q;
    assign o_init_done       = (state_q != S_INIT);
    assign o_test_pheromones = table_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            op_q        <= 1'b0;
            dest_q      <= '0;
            avail_q     <= '0;
            parent_q    <= '0;
            dest_ok_q   <= 1'b0;
            row_q       <= '0;
            table_q     <= '0;
            rsp_port_q  <= '0;
            rsp_value_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_INIT: begin
                    table_q[cnt_q] <= {(N - 1){PH_WIDTH'(PH_INIT)}};
                    if (cnt_q == DW'(NODES - 1)) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                S_IDLE: begin
                    if (gnt_any) begin
                        gnt_q    <= gnt_sel;
                        op_q     <= i_op[gnt_sel];
                        dest_q   <= i_dest[gnt_sel];
                        avail_q  <= i_avail[gnt_sel];
                        parent_q <= i_parent[gnt_sel];
                        if (int'(gnt_sel) == N - 1) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= gnt_sel + PW'(1);
                        end
                    end
                end
                S_READ: begin
                    dest_ok_q <= dest_ok;
                    row_q     <= dest_ok ? table_q[dest_q] : '0;
                end
                S_EXEC: begin
                    if (op_q && dest_ok_q) begin
                        table_q[dest_q] <= new_row;
                    end
                    rsp_port_q  <= exec_port;
                    rsp_value_q <= exec_value;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ph_table_ctrl.sv
// Scoreboarded bench for ph_table_ctrl: directed cases plus random traffic
// checked against an arithmetic model of the pheromone table.
module tb_ph_table_ctrl;

    localparam int N        = 5;
    localparam int NODES    = 16;
    localparam int PH_WIDTH = 4;
    localparam int PH_MAX   = 15;
    localparam int PH_MIN   = 0;
    localparam int PH_INIT  = 8;
    localparam int PH_INC   = 2;
    localparam int DW       = $clog2(NODES);
    localparam int PW       = $clog2(N);

    logic                                  clk   = 1'b0;
    logic                                  reset = 1'b1;
    logic [0:N-1]                          i_req = '0;
    logic [0:N-1]                          i_op  = '0;
    logic [0:N-1][DW-1:0]                  i_dest = '0;
    logic [0:N-1][0:N-2]                   i_avail = '0;
    logic [0:N-1][PW-1:0]                  i_parent = '0;
    logic [0:N-1]                          o_gnt;
    logic [0:N-1]                          o_rsp_valid;
    logic [PW-1:0]                         o_rsp_port;
    logic [PH_WIDTH-1:0]                   o_rsp_value;
    logic                                  o_init_done;
    logic [0:NODES-1][0:N-2][PH_WIDTH-1:0] o_test_pheromones;

    typedef struct {
        int port;
        int rport;
        int rval;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    int   ph[NODES][N-1];
    int   last_gnt = N - 1;
    int   last_gcyc = 0;
    bit   have_prev = 0;
    bit   fair = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   held_port = 0;
    int   held_val = 0;

    ph_table_ctrl #(
        .N(N), .NODES(NODES), .PH_WIDTH(PH_WIDTH), .PH_MAX(PH_MAX),
        .PH_MIN(PH_MIN), .PH_INIT(PH_INIT), .PH_INC(PH_INC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_op(i_op),
        .i_dest(i_dest),
        .i_avail(i_avail),
        .i_parent(i_parent),
        .o_gnt(o_gnt),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_port(o_rsp_port),
        .o_rsp_value(o_rsp_value),
        .o_init_done(o_init_done),
        .o_test_pheromones(o_test_pheromones)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    function automatic logic [0:N-1] onehot(int k);
        logic [0:N-1] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++)
                ph[r][c] = PH_INIT;
        last_gnt = N - 1;
    endfunction

    // Reference behaviour of one accepted request, applied at grant time.
    function automatic exp_t model_exec(int k);
        exp_t x;
        int d, p, best;
        x.port = k;
        x.gcyc = 0;
        d = int'(i_dest[k]);
        if (i_op[k]) begin
            p = int'(i_parent[k]);
            x.rport = p;
            x.rval  = 0;
            if (d < NODES) begin
                for (int c = 0; c < N - 1; c++) begin
                    if (p >= 1 && p <= N - 1 && c == p - 1) begin
                        ph[d][c] = (ph[d][c] + PH_INC > PH_MAX) ? PH_MAX : ph[d][c] + PH_INC;
                        x.rval   = ph[d][c];
                    end else begin
                        ph[d][c] = (ph[d][c] - 1 < PH_MIN) ? PH_MIN : ph[d][c] - 1;
                    end
                end
            end
        end else begin
            best = -1;
            if (d < NODES)
                for (int c = 0; c < N - 1; c++)
                    if (i_avail[k][c] && (best < 0 || ph[d][c] > ph[d][best]))
                        best = c;
            x.rport = best + 1;
            x.rval  = (best < 0) ? 0 : ph[d][best];
        end
        return x;
    endfunction

    // Grant watcher: checks arbitration and pushes expected responses.
    always @(negedge clk) begin
        int k;
        exp_t x;
        if (reset) begin
            sb.delete();
            model_reset();
            have_prev = 0;
        end else begin
            if (!fair) have_prev = 0;
            if (!o_init_done) chk("gnt_during_init", o_gnt, 0);
            if (o_gnt != '0) begin
                k = -1;
                for (int i = 1; i <= N; i++)
                    if (k < 0 && i_req[(last_gnt + i) % N]) k = (last_gnt + i) % N;
                if (k < 0) begin
                    chk("gnt_without_req", o_gnt, 0);
                end else begin
                    chk("gnt_port", o_gnt, onehot(k));
                    chk("gnt_init_done", o_init_done, 1);
                    if (fair && have_prev) chk("gnt_spacing", cyc - last_gcyc, 3);
                    have_prev = fair;
                    last_gcyc = cyc;
                    last_gnt  = k;
                    x = model_exec(k);
                    x.gcyc = cyc;
                    sb.push_back(x);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            held_port = 0;
            held_val  = 0;
            chk("rsp_valid_in_reset", o_rsp_valid, 0);
        end else if (o_rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", o_rsp_valid, 0);
            end else begin
                x = sb.pop_front();
                chk("rsp_valid_port", o_rsp_valid, onehot(x.port));
                chk("rsp_port", o_rsp_port, x.rport);
                chk("rsp_value", o_rsp_value, x.rval);
                chk("rsp_latency", cyc - x.gcyc, 2);
                held_port = x.rport;
                held_val  = x.rval;
            end
        end else begin
            chk("rsp_port_hold", o_rsp_port, held_port);
            chk("rsp_value_hold", o_rsp_value, held_val);
        end
    end

    task automatic set_rand(int k);
        i_op[k]     = 1'($urandom_range(0, 1));
        i_dest[k]   = DW'($urandom_range(0, NODES - 1));
        i_avail[k]  = (N - 1)'($urandom);
        i_parent[k] = PW'($urandom_range(0, (1 << PW) - 1));
    endtask

    // Hold each requester until its grant has been seen, then drop it.
    task automatic drive_round(logic [0:N-1] m);
        logic [0:N-1] pend;
        int t;
        pend  = m;
        i_req = pend;
        t     = 0;
        while (pend != '0 && t < 200) begin
            @(negedge clk);
            pend = pend & ~o_gnt;
            t++;
            @(posedge clk);
            #1;
            i_req = pend;
        end
        chk("grant_timeout", pend, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_table();
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++)
                chk($sformatf("table[%0d][%0d]", r, c), o_test_pheromones[r][c], ph[r][c]);
    endtask

    task automatic init_check();
        int n;
        n = 0;
        while (!o_init_done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("init_cycles", n, NODES);
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++)
                chk($sformatf("init[%0d][%0d]", r, c), o_test_pheromones[r][c], PH_INIT);
    endtask

    initial begin
        logic [0:N-1] m;
        int t, g, gk;

        repeat (3) @(negedge clk);
        chk("reset_gnt", o_gnt, 0);
        chk("reset_rsp_valid", o_rsp_valid, 0);
        chk("reset_init_done", o_init_done, 0);
        chk("reset_rsp_port", o_rsp_port, 0);
        chk("reset_rsp_value", o_rsp_value, 0);

        // A lookup held through init must wait until the table is ready.
        @(posedge clk);
        #1;
        set_rand(3);
        i_op[3] = 1'b0;
        reset   = 1'b0;
        fork
            drive_round(onehot(3));
            init_check();
        join
        wait_idle();

        i_op[2] = 1'b0; i_dest[2] = 4'd5; i_avail[2] = 4'b1111;
        drive_round(onehot(2));
        wait_idle();
        chk("dir_lookup_port", o_rsp_port, 1);
        chk("dir_lookup_value", o_rsp_value, 8);

        i_op[1] = 1'b1; i_dest[1] = 4'd5; i_parent[1] = 3'd3;
        drive_round(onehot(1));
        wait_idle();
        chk("dir_update_port", o_rsp_port, 3);
        chk("dir_update_value", o_rsp_value, 10);
        chk("row5_c0", o_test_pheromones[5][0], 7);
        chk("row5_c1", o_test_pheromones[5][1], 7);
        chk("row5_c2", o_test_pheromones[5][2], 10);
        chk("row5_c3", o_test_pheromones[5][3], 7);

        i_op[4] = 1'b0; i_dest[4] = 4'd5; i_avail[4] = 4'b1011;
        drive_round(onehot(4));
        wait_idle();
        chk("dir_masked_port", o_rsp_port, 3);
        chk("dir_masked_value", o_rsp_value, 10);

        // Saturation at the ceiling and the floor.
        for (int i = 0; i < 10; i++) begin
            i_op[0] = 1'b1; i_dest[0] = 4'd0; i_parent[0] = 3'd1;
            drive_round(onehot(0));
            wait_idle();
            check_table();
        end
        chk("sat_c0", o_test_pheromones[0][0], PH_MAX);
        chk("sat_c1", o_test_pheromones[0][1], PH_MIN);
        chk("sat_c2", o_test_pheromones[0][2], PH_MIN);
        chk("sat_c3", o_test_pheromones[0][3], PH_MIN);

        for (int i = 0; i < 25; i++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++)
                if (m[k]) set_rand(k);
            drive_round(m);
            wait_idle();
            check_table();
        end

        // Reset while an update sits in the read stage.
        i_op[0] = 1'b1; i_dest[0] = 4'd7; i_parent[0] = 3'd2;
        i_req = onehot(0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_gnt[0] && t < 20);
        chk("mid_gnt", o_gnt[0], 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_valid", o_rsp_valid, 0);
            chk("mid_rst_done", o_init_done, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_check();
        @(posedge clk);
        #1;

        // All ports held: grants rotate 0..N-1 every 3 cycles.
        fair = 1;
        for (int k = 0; k < N; k++) set_rand(k);
        i_req = '1;
        g = 0;
        t = 0;
        while (i_req != '0 && t < 200) begin
            @(negedge clk);
            t++;
            gk = -1;
            for (int k = 0; k < N; k++)
                if (o_gnt[k]) gk = k;
            @(posedge clk);
            #1;
            if (gk >= 0) begin
                g++;
                if (g <= 2 * N) chk("fair_order", gk, (g - 1) % N);
                if (g < 2 * N) set_rand(gk);
                else i_req[gk] = 1'b0;
            end
        end
        chk("fair_drain", i_req, 0);
        fair = 0;
        wait_idle();
        check_table();

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
